// File: rtl/jvm_insn_assembler.sv
// jvm_insn_assembler: gathers a serial JVM bytecode stream into whole
// instructions (opcode plus the fixed operand bytes listed in the count table)
// and holds each complete record until the translator downstream accepts it.
// Optional feature macro: INSN_PC_EN adds the bytecode PC tracker and the
// flush_pc / insn_pc ports.
module jvm_insn_assembler #(
    parameter int MAX_PARAMS = 16,
    parameter int PC_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    insn_valid,
    input  logic                    insn_ready,
    output logic [7:0]              insn_opcode,
    output logic [MAX_PARAMS*8-1:0] insn_params,
`ifdef INSN_PC_EN
    input  logic [PC_W-1:0]         flush_pc,
    output logic [PC_W-1:0]         insn_pc,
`endif
    output logic [4:0]              insn_count
);

    // Width of an operand count; must hold the largest table entry (16).
    localparam int PARAM_LEN = 5;

    localparam logic [1:0] ST_OPC = 2'd0;
    localparam logic [1:0] ST_PAR = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    // Fixed operand-byte count per opcode. Switch opcodes get a fixed length
    // because alignment padding is resolved elsewhere.
    function automatic logic [PARAM_LEN-1:0] count_rom(input logic [7:0] op);
        logic [PARAM_LEN-1:0] c;
        c = '0;
        case (op) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC:
                c = PARAM_LEN'(1);
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                c = PARAM_LEN'(2);
            8'hC4, 8'hC5:
                c = PARAM_LEN'(3);
            8'hB9, 8'hBA, 8'hC8, 8'hC9:
                c = PARAM_LEN'(4);
            8'hAB:
                c = PARAM_LEN'(8);
            8'hAA:
                c = PARAM_LEN'(16);
            default:
                c = '0;
        endcase
        return c;
    endfunction

    logic [1:0]           r_state;
    logic [7:0]           r_opcode;
    logic [PARAM_LEN-1:0] r_count;
    logic [PARAM_LEN-1:0] r_rem;
    logic [MAX_PARAMS*8-1:0] r_params;

    logic                 w_accept;
    logic                 w_opc_accept;
    logic                 w_par_accept;
    logic [PARAM_LEN-1:0] w_tbl_count;
    logic [PARAM_LEN-1:0] w_idx;

    assign byte_ready   = rst_n & ~flush & (r_state != ST_OUT);
    assign w_accept     = byte_valid & byte_ready;
    assign w_opc_accept = w_accept & (r_state == ST_OPC);
    assign w_par_accept = w_accept & (r_state == ST_PAR);
    assign w_tbl_count  = count_rom(byte_in);
    assign w_idx        = r_count - r_rem;

    assign insn_valid  = (r_state == ST_OUT);
    assign insn_opcode = r_opcode;
    assign insn_count  = r_count;
    assign insn_params = r_params;

    // Sequencer: opcode -> operand collection -> hold record until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_OPC;
            r_opcode <= '0;
            r_count  <= '0;
            r_rem    <= '0;
        end else if (flush) begin
            r_state <= ST_OPC;
            r_rem   <= '0;
        end else begin
            case (r_state)
                ST_OPC: begin
                    if (w_accept) begin
                        r_opcode <= byte_in;
                        r_count  <= w_tbl_count;
                        r_rem    <= w_tbl_count;
                        r_state  <= (w_tbl_count == '0) ? ST_OUT : ST_PAR;
                    end
                end
                ST_PAR: begin
                    if (w_accept) begin
                        r_rem <= r_rem - PARAM_LEN'(1);
                        if (r_rem == PARAM_LEN'(1)) begin
                            r_state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (insn_ready) begin
                        r_state <= ST_OPC;
                    end
                end
                default: r_state <= ST_OPC;
            endcase
        end
    end

    // One register per operand byte; operands beyond capacity never match an
    // index here, so they are consumed without being stored.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PARAMS; gi++) begin : g_param
            logic w_wr;
            assign w_wr = w_par_accept & (32'(w_idx) == gi);

            // Clear on a new opcode or flush, capture the matching operand.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_params[8*gi +: 8] <= '0;
                end else if (flush || w_opc_accept) begin
                    r_params[8*gi +: 8] <= '0;
                end else if (w_wr) begin
                    r_params[8*gi +: 8] <= byte_in;
                end
            end
        end
    endgenerate

`ifdef INSN_PC_EN
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_insn_pc;

    assign insn_pc = r_insn_pc;

    // Byte-granular PC; the record carries the PC of its opcode byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_insn_pc <= '0;
        end else if (flush) begin
            r_pc <= flush_pc;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_opc_accept) begin
                r_insn_pc <= r_pc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jvm_insn_assembler.sv
// Testbench for jvm_insn_assembler: scoreboard of expected instruction
// records, popped and compared whenever the DUT hands a record downstream.
module tb_jvm_insn_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         insn_valid;
    logic         insn_ready;
    logic [7:0]   insn_opcode;
    logic [127:0] insn_params;
    logic [4:0]   insn_count;
    logic [15:0]  flush_pc;
    logic [15:0]  insn_pc;

    typedef struct packed {
        logic [7:0]   op;
        logic [4:0]   cnt;
        logic [127:0] params;
        logic [15:0]  pc;
    } rec_t;

    rec_t        sb[$];
    logic [15:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    jvm_insn_assembler #(.MAX_PARAMS(16), .PC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn_opcode (insn_opcode),
        .insn_params (insn_params),
`ifdef INSN_PC_EN
        .flush_pc    (flush_pc),
        .insn_pc     (insn_pc),
`endif
        .insn_count  (insn_count)
    );

`ifndef INSN_PC_EN
    assign insn_pc = '0;
`endif

    // Scoreboard monitor: every handshake pops one expected record.
    always @(negedge clk) begin
        if (rst_n && insn_valid && insn_ready) begin
            $display("record op=%02h cnt=%0d params=%032h pc=%04h",
                     insn_opcode, insn_count, insn_params, insn_pc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got op=%02h, none expected", insn_opcode);
            end else begin
                rec_t e;
                e = sb.pop_front();
                if (insn_opcode !== e.op || insn_count !== e.cnt || insn_params !== e.params
`ifdef INSN_PC_EN
                    || insn_pc !== e.pc
`endif
                   ) begin
                    errors++;
                    $display("FAIL record: got op=%02h cnt=%0d params=%032h pc=%04h, expected op=%02h cnt=%0d params=%032h pc=%04h",
                             insn_opcode, insn_count, insn_params, insn_pc,
                             e.op, e.cnt, e.params, e.pc);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] op, input logic [4:0] cnt, input logic [127:0] p);
        rec_t e;
        e.op = op; e.cnt = cnt; e.params = p; e.pc = m_pc;
        sb.push_back(e);
    endtask

    // Offer one byte and wait (bounded) for it to be accepted.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            m_pc = m_pc + 16'd1;
        end else begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte %02h not accepted, required within 200 cycles", b);
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [15:0] pc);
        flush = 1'b1;
        flush_pc = pc;
        byte_in = 8'h55;
        byte_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_byte_ready: got %b, required 0", byte_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        byte_valid = 1'b0;
        m_pc = pc;
    endtask

    task automatic wait_drain;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d records outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        flush = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        insn_ready = 1'b1;
        flush_pc = 16'h0000;
        m_pc = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b, required 0", byte_ready); end
        checks++;
        if (insn_valid !== 1'b0) begin errors++; $display("FAIL reset_insn_valid: got %b, required 0", insn_valid); end
        checks++;
        if (insn_opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %02h, required 00", insn_opcode); end
        checks++;
        if (insn_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", insn_count); end
        checks++;
        if (insn_params !== 128'd0) begin errors++; $display("FAIL reset_params: got %032h, required 0", insn_params); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_release_byte_ready: got %b, required 1", byte_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int s0, s1, s2;
        insn_ready = 1'b1;
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s0);
        checks++;
        if (insn_valid !== 1'b1) begin errors++; $display("FAIL iadd_valid_latency: got %b, required 1", insn_valid); end
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s1);
        checks++;
        if (s1 != 1) begin errors++; $display("FAIL iadd_rearm_gap1: got %0d stall cycles, required 1", s1); end
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s2);
        checks++;
        if (s2 != 1) begin errors++; $display("FAIL iadd_rearm_gap2: got %0d stall cycles, required 1", s2); end
        wait_drain();
    endtask

    task automatic test_sipush_gap;
        int s;
        insn_ready = 1'b1;
        push_exp(8'h11, 5'd2, 128'h3412);
        send_byte(8'h11, s);
        send_byte(8'h12, s);
        @(posedge clk);
        #1;
        checks++;
        if (insn_valid !== 1'b0) begin errors++; $display("FAIL sipush_gap_valid: got %b, required 0", insn_valid); end
        send_byte(8'h34, s);
        wait_drain();
    endtask

    task automatic test_tableswitch_stall;
        int s;
        logic [127:0] exp_p;
        for (int i = 0; i < 16; i++) exp_p[8*i +: 8] = 8'(i + 1);
        insn_ready = 1'b0;
        push_exp(8'hAA, 5'd16, exp_p);
        send_byte(8'hAA, s);
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), s);
        byte_in = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (insn_valid !== 1'b1 || byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_handshake: cycle %0d valid=%b ready=%b, required valid=1 ready=0", c, insn_valid, byte_ready);
            end
            checks++;
            if (insn_opcode !== 8'hAA || insn_count !== 5'd16 || insn_params !== exp_p) begin
                errors++;
                $display("FAIL stall_record: cycle %0d op=%02h cnt=%0d params=%032h, required op=aa cnt=16 params=%032h",
                         c, insn_opcode, insn_count, insn_params, exp_p);
            end
        end
        @(posedge clk);
        #1;
        insn_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_flush;
        int s;
        insn_ready = 1'b1;
        send_byte(8'hA7, s);
        send_byte(8'h01, s);
        do_flush(16'h0040);
        checks++;
        if (insn_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", insn_valid); end
        push_exp(8'h10, 5'd1, 128'h7F);
        send_byte(8'h10, s);
        send_byte(8'h7F, s);
        wait_drain();
    endtask

    task automatic test_reset_mid;
        int s;
        insn_ready = 1'b1;
        send_byte(8'hB9, s);
        send_byte(8'h01, s);
        send_byte(8'h02, s);
        rst_n = 1'b0;
        #1;
        m_pc = 16'h0000;
        checks++;
        if (byte_ready !== 1'b0 || insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_handshake: ready=%b valid=%b, required 0 0", byte_ready, insn_valid);
        end
        checks++;
        if (insn_opcode !== 8'h00 || insn_count !== 5'd0 || insn_params !== 128'd0 || insn_pc !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_record: op=%02h cnt=%0d params=%032h pc=%04h, required all 0",
                     insn_opcode, insn_count, insn_params, insn_pc);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready: got %b, required 1", byte_ready); end
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s);
        wait_drain();
    endtask

`ifdef INSN_PC_EN
    task automatic test_pc;
        int s;
        insn_ready = 1'b1;
        do_flush(16'h0100);
        push_exp(8'h10, 5'd1, 128'h05);
        send_byte(8'h10, s);
        send_byte(8'h05, s);
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s);
        wait_drain();
        checks++;
        if (insn_pc !== 16'h0102) begin errors++; $display("FAIL pc_second: got %04h, required 0102", insn_pc); end
        do_flush(16'hFFFF);
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s);
        push_exp(8'h60, 5'd0, 128'd0);
        send_byte(8'h60, s);
        wait_drain();
        checks++;
        if (insn_pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %04h, required 0000", insn_pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_sipush_gap();
        test_tableswitch_stall();
        test_flush();
        test_reset_mid();
`ifdef INSN_PC_EN
        test_pc();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d records, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jvm_insn_assembler.md
# jvm_insn_assembler

- Assembles a serial JVM bytecode byte stream into whole instructions: one opcode plus its operand bytes.
- Looks up each opcode's operand-byte count from the opcode count table (`count_rom`, `PARAM_LEN`-bit count from `me_consts.vh`).
- Collects exactly that many following bytes and presents the complete instruction to the translator downstream.
- Sits between the bytecode fetch buffer and the JVM→ARM translation stage.

## Interface

Parameters:

- `MAX_PARAMS`, 16: operand byte capacity. Must be ≥1. Default covers the largest table count (16).
- `PC_W`, 16: bytecode PC width. Used only with `INSN_PC_EN`.

Ports:

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous discard of any partial or held instruction.
- `byte_in`  in  8  bytecode byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  byte accepted when `byte_valid & byte_ready`.
- `insn_valid`  out  1  instruction record valid.
- `insn_ready`  in  1  downstream accepts the record.
- `insn_opcode`  out  8  opcode.
- `insn_params`  out  `MAX_PARAMS*8`  operands. Operand i is at `[8i+7:8i]` (first operand at byte 0). Unfilled bytes are 0.
- `insn_count`  out  `PARAM_LEN`  operand count from the table.
- `flush_pc`  in  `PC_W`  PC loaded on flush (`INSN_PC_EN` only).
- `insn_pc`  out  `PC_W`  PC of the opcode byte (`INSN_PC_EN` only).

## Operation

States:

- **OPC**
  - `byte_ready`=1.
  - On accept: latch opcode, latch table count into `insn_count` and the remaining counter `rem`, clear `insn_params`.
  - Next state: count=0 → OUT; otherwise → PAR.
- **PAR**
  - `byte_ready`=1.
  - On accept: store the byte at index `insn_count-rem`. Indices ≥`MAX_PARAMS` are consumed and dropped. Then `rem`←`rem`-1.
  - When `rem`==1 at accept → OUT.
- **OUT**
  - `byte_ready`=0, `insn_valid`=1.
  - `insn_valid & insn_ready` → OPC.
  - All record outputs hold stable while `insn_valid` is high.

General rules:

- `byte_valid` gaps in PAR simply stall; no timeout.
- `flush` has top priority in every state:
  - next state OPC; `insn_valid`=0, `rem`=0, params cleared.
  - `byte_ready` is forced 0 in the flush cycle, so no byte is consumed.
- Table counts are fixed per opcode. Alignment padding and variable switch lengths are not handled here.
- `rem` is `PARAM_LEN` bits; no wrap is possible because it is only decremented while nonzero.
- Reset values: state OPC, `insn_valid`=0, `insn_opcode`=0, `insn_params`=0, `insn_count`=0, `insn_pc`=0, `byte_ready`=0 while `rst_n` is low.

## Timing

- `byte_ready` is combinational: `rst_n & ~flush & (state!=OUT)`.
- Zero-operand opcode accepted at edge N → `insn_valid` high after edge N (visible in cycle N+1).
- Operand count k: last operand accepted at edge N+k → `insn_valid` high in cycle N+k+1.
- No bypass from OUT to OPC: the next opcode is accepted no earlier than the cycle after the handshake.
- Peak throughput: one instruction per k+2 cycles.
- `insn_ready` low holds OUT indefinitely.
- Reset mid-instruction: immediate return to reset values; no partial record ever appears.

## Configuration

`INSN_PC_EN`:

- **Defined:**
  - `pc` register (`PC_W` bits, reset 0) increments by 1 on every accepted byte and wraps modulo 2^`PC_W`.
  - On opcode accept, `insn_pc` latches the current `pc`.
  - `flush` loads `pc`←`flush_pc`.
  - Ports `flush_pc` and `insn_pc` exist.
- **Undefined:** no PC logic; `flush_pc` and `insn_pc` ports are absent; all other behaviour is identical.

## Test plan

- `iadd` 0x60 streamed back-to-back, `insn_ready`=1 → `insn_valid` cycle after accept, opcode 0x60, count 0, params 0; next opcode accepted one cycle after handshake.
- `sipush` 0x11,0x12,0x34 with one-cycle `byte_valid` gap between operands → opcode 0x11, count 2, `params[7:0]`=0x12, `params[15:8]`=0x34, all other bytes 0.
- `tableswitch` 0xAA plus 16 bytes 0x01..0x10 → count 16, `params[127:120]`=0x10; `insn_ready` held low 5 cycles → record stable, `byte_ready`=0 throughout.
- `goto` 0xA7, one operand accepted, then `flush` → no `insn_valid`. Next stream `bipush` 0x10,0x7F → opcode 0x10, params 0x7F.
- `rst_n` pulsed low during PAR of `invokeinterface` 0xB9 → all outputs 0, state OPC; `byte_ready` rises the first cycle `rst_n` is high.
- `INSN_PC_EN`: flush with `flush_pc`=0x0100, then stream 0x10 0x05 0x60 → `insn_pc` 0x0100, then 0x0102; `pc` wraps 0xFFFF→0x0000.
